// File: rtl/cpu_per_pkg.sv
// Shared encodings for the CPU / peripheral four-phase send/ack channel.
// Used by the CPU-side FSMs, the peripheral FSM and the channel arbiter.
package cpu_per_pkg;

    localparam int unsigned DEF_DW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        ACKD = 2'b10,
        REL  = 2'b11
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, cyclic.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                win_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one four-phase send/ack peripheral channel
// between N_REQ requesters, with ack timeout and completed-transfer counter.
module handshake_arbiter
    import cpu_per_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned TO_CYCLES = 255,
    parameter int unsigned CW        = 8
) (
    input  logic                clk2,
    input  logic                rst2,
    input  logic [N_REQ-1:0]    req_send,
    input  logic [N_REQ*DW-1:0] req_dado,
    output logic [N_REQ-1:0]    req_ack,
    output logic [N_REQ-1:0]    req_err,
    output logic                per_send,
    output logic [DW-1:0]       per_dado,
    input  logic                per_ack,
    output logic [N_REQ-1:0]    grant,
    output logic                busy,
    output logic [CW-1:0]       xfer_cnt
);

    localparam int unsigned PW      = (N_REQ < 2) ? 1 : $clog2(N_REQ);
    localparam int unsigned TOW     = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
    localparam int unsigned TO_LAST = (TO_CYCLES == 0) ? 0 : TO_CYCLES - 1;

    arb_state_e       state_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [TOW-1:0]   to_cnt_q;
    logic             to_flag_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] err_q;
    logic             per_send_q;
    logic [DW-1:0]    per_dado_q;
    logic             busy_q;
    logic [CW-1:0]    xfer_cnt_q;

    logic [N_REQ-1:0] pick_oh_c;
    logic             pick_vld_c;
    logic [DW-1:0]    pick_dado_c;
    logic [PW-1:0]    own_idx_c;
    logic [PW-1:0]    rr_next_c;
    logic             own_send_c;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req_i   (req_send),
        .ptr_i   (rr_ptr_q),
        .win_o   (pick_oh_c),
        .valid_o (pick_vld_c)
    );

    // Winner's data word and the current owner's index, both from one-hot vectors.
    always_comb begin
        pick_dado_c = '0;
        own_idx_c   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_oh_c[i]) pick_dado_c = pick_dado_c | req_dado[i*DW +: DW];
            if (grant_q[i])   own_idx_c   = own_idx_c | PW'(i);
        end
        rr_next_c  = (own_idx_c == PW'(N_REQ - 1)) ? '0 : own_idx_c + PW'(1);
        own_send_c = |(req_send & grant_q);
    end

    always_ff @(posedge clk2 or negedge rst2) begin
        if (!rst2) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            per_send_q <= 1'b0;
            per_dado_q <= '0;
            busy_q     <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A still-high ack from a previous owner blocks new grants.
                    if (pick_vld_c && !per_ack) begin
                        grant_q    <= pick_oh_c;
                        per_dado_q <= pick_dado_c;
                        per_send_q <= 1'b1;
                        busy_q     <= 1'b1;
                        to_cnt_q   <= '0;
                        to_flag_q  <= 1'b0;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (per_ack) begin
                        ack_q   <= grant_q;
                        err_q   <= '0;
                        state_q <= ACKD;
                    end else if (TO_CYCLES != 0 && to_cnt_q == TOW'(TO_LAST)) begin
                        per_send_q <= 1'b0;
                        ack_q      <= grant_q;
                        err_q      <= grant_q;
                        to_flag_q  <= 1'b1;
                        state_q    <= ACKD;
                    end else begin
                        to_cnt_q <= to_cnt_q + TOW'(1);
                    end
                end
                ACKD: begin
                    if (!own_send_c) begin
                        ack_q      <= '0;
                        err_q      <= '0;
                        per_send_q <= 1'b0;
                        state_q    <= REL;
                    end
                end
                REL: begin
                    if (!per_ack) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_next_c;
                        busy_q   <= 1'b0;
                        if (!to_flag_q) xfer_cnt_q <= xfer_cnt_q + CW'(1);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack  = ack_q;
    assign req_err  = err_q;
    assign per_send = per_send_q;
    assign per_dado = per_dado_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed self-checking bench for handshake_arbiter (N_REQ=2, DW=2, TO_CYCLES=4, CW=2).
module tb_handshake_arbiter;

    logic       clk2 = 1'b0;
    logic       rst2;
    logic [1:0] req_send;
    logic [3:0] req_dado;
    logic [1:0] req_ack;
    logic [1:0] req_err;
    logic       per_send;
    logic [1:0] per_dado;
    logic       per_ack;
    logic [1:0] grant;
    logic       busy;
    logic [1:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    handshake_arbiter #(
        .N_REQ     (2),
        .DW        (2),
        .TO_CYCLES (4),
        .CW        (2)
    ) dut (
        .clk2     (clk2),
        .rst2     (rst2),
        .req_send (req_send),
        .req_dado (req_dado),
        .req_ack  (req_ack),
        .req_err  (req_err),
        .per_send (per_send),
        .per_dado (per_dado),
        .per_ack  (per_ack),
        .grant    (grant),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        @(negedge clk2);
    endtask

    // One full handshake for the expected winner g; requesters then show send_after.
    task automatic xfer(input string tag, input logic [1:0] g, input logic [1:0] d,
                        input logic [1:0] send_after, input logic [1:0] cnt);
        tick();
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".per_send"}, 32'(per_send), 32'd1);
        chk({tag, ".per_dado"}, 32'(per_dado), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".ack_early"}, 32'(req_ack), 32'd0);
        per_ack = 1'b1;
        tick();
        chk({tag, ".req_ack"}, 32'(req_ack), 32'(g));
        chk({tag, ".req_err"}, 32'(req_err), 32'd0);
        req_send = req_send & ~g;
        tick();
        chk({tag, ".ack_drop"}, 32'(req_ack), 32'd0);
        chk({tag, ".send_drop"}, 32'(per_send), 32'd0);
        chk({tag, ".grant_rel"}, 32'(grant), 32'(g));
        per_ack  = 1'b0;
        req_send = send_after;
        tick();
        chk({tag, ".grant_idle"}, 32'(grant), 32'd0);
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
        chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(cnt));
    endtask

    initial begin
        rst2     = 1'b0;
        req_send = 2'b00;
        req_dado = 4'b0000;
        per_ack  = 1'b0;

        @(negedge clk2);
        chk("rst.per_send", 32'(per_send), 32'd0);
        chk("rst.grant", 32'(grant), 32'd0);
        chk("rst.req_ack", 32'(req_ack), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.xfer_cnt", 32'(xfer_cnt), 32'd0);

        // Single requester 0 with data 10.
        rst2     = 1'b1;
        req_send = 2'b01;
        req_dado = 4'b0010;
        xfer("single", 2'b01, 2'b10, 2'b00, 2'd1);

        // Requester 1 (pointer now 1), async reset while in ACKD.
        req_send = 2'b10;
        req_dado = 4'b1001;
        tick();
        chk("arst.grant_pre", 32'(grant), 32'b10);
        chk("arst.dado_pre", 32'(per_dado), 32'b10);
        per_ack = 1'b1;
        tick();
        chk("arst.ack_pre", 32'(req_ack), 32'b10);
        #2 rst2 = 1'b0;
        #1;
        chk("arst.per_send", 32'(per_send), 32'd0);
        chk("arst.req_ack", 32'(req_ack), 32'd0);
        chk("arst.grant", 32'(grant), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.xfer_cnt", 32'(xfer_cnt), 32'd0);
        @(negedge clk2);
        rst2     = 1'b1;
        per_ack  = 1'b0;
        req_send = 2'b11;

        // Both requesting continuously: alternation from pointer 0, counter wraps.
        xfer("rr1", 2'b01, 2'b01, 2'b11, 2'd1);
        xfer("rr2", 2'b10, 2'b10, 2'b11, 2'd2);
        xfer("rr3", 2'b01, 2'b01, 2'b11, 2'd3);
        xfer("rr4", 2'b10, 2'b10, 2'b11, 2'd0);
        xfer("rr5", 2'b01, 2'b01, 2'b00, 2'd1);

        // Timeout: requester 1, peripheral never acks.
        req_send = 2'b10;
        tick();
        chk("to.grant", 32'(grant), 32'b10);
        for (int k = 0; k < 4; k++) begin
            chk("to.per_send_held", 32'(per_send), 32'd1);
            chk("to.no_ack", 32'(req_ack), 32'd0);
            tick();
        end
        chk("to.per_send_fall", 32'(per_send), 32'd0);
        chk("to.req_ack", 32'(req_ack), 32'b10);
        chk("to.req_err", 32'(req_err), 32'b10);
        per_ack  = 1'b1;
        req_send = 2'b00;
        tick();
        chk("to.ack_drop", 32'(req_ack), 32'd0);
        chk("to.err_drop", 32'(req_err), 32'd0);
        tick();
        chk("to.late_ack_hold", 32'(busy), 32'd1);
        chk("to.late_ack_grant", 32'(grant), 32'b10);
        per_ack = 1'b0;
        tick();
        chk("to.idle", 32'(busy), 32'd0);
        chk("to.xfer_cnt", 32'(xfer_cnt), 32'd1);

        // Stale ack held at reset release blocks the grant.
        rst2     = 1'b0;
        per_ack  = 1'b1;
        req_send = 2'b01;
        @(negedge clk2);
        rst2 = 1'b1;
        tick();
        chk("stale.grant1", 32'(grant), 32'd0);
        chk("stale.per_send1", 32'(per_send), 32'd0);
        tick();
        chk("stale.grant2", 32'(grant), 32'd0);
        chk("stale.busy2", 32'(busy), 32'd0);
        per_ack = 1'b0;
        xfer("stale", 2'b01, 2'b01, 2'b00, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_arbiter.md
Name: handshake_arbiter

Overview:
- Shares one four-phase send/ack peripheral channel between N_REQ CPU-side requesters.
- Each requester drives send plus a data word and waits for ack, exactly as a CPU FSM talks to the peripheral.
- The arbiter grants round-robin, forwards the winner's data, and relays the peripheral ack back to the winner.
- Provides a per-transaction timeout and a completed-transfer counter.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DW, 2, data word width.
- TO_CYCLES, 255, cycles to wait for peripheral ack in REQ before timeout; 0 disables the timeout.
- CW, 8, width of the completed-transfer counter.

Ports:
- clk2  in  1  clock; all state updates on its rising edge.
- rst2  in  1  reset, asynchronous, active-low (0 = reset).
- req_send  in  N_REQ  per-requester send.
- req_dado  in  N_REQ*DW  per-requester data; slice i = bits [i*DW +: DW].
- req_ack  out  N_REQ  per-requester ack; one-hot or zero.
- req_err  out  N_REQ  per-requester error, valid while the matching req_ack=1.
- per_send  out  1  send toward the peripheral.
- per_dado  out  DW  data toward the peripheral.
- per_ack  in  1  ack from the peripheral.
- grant  out  N_REQ  one-hot current owner; zero when idle.
- busy  out  1  1 in any state other than IDLE.
- xfer_cnt  out  CW  completed transfers, wrapping.

Behaviour:
- All outputs are registered. Reset (rst2=0, asynchronous) drives every output to 0, state=IDLE, rr_ptr=0, timeout counter=0.
- States:
  - IDLE: if any req_send=1 and per_ack=0, select winner W as the first set req_send at or after rr_ptr (cyclic). Next cycle: grant=onehot(W), per_dado=req_dado[W] (latched), per_send=1, state=REQ.
  - IDLE with per_ack=1 (stale): stay in IDLE, grant nothing.
  - REQ: per_send held 1; per_dado holds the latched value, and requester data changes are ignored.
    - On per_ack=1: next cycle req_ack[W]=1, req_err[W]=0, state=ACKD.
    - Timeout counter counts cycles in REQ. If TO_CYCLES!=0 and the count reaches TO_CYCLES with per_ack=0: next cycle per_send=0, req_ack[W]=1, req_err[W]=1, state=ACKD.
  - ACKD: on req_send[W]=0, next cycle req_ack[W]=0, req_err[W]=0, per_send=0, state=REL.
  - REL: wait for per_ack=0. Next cycle: grant=0, rr_ptr=(W+1) mod N_REQ, xfer_cnt+=1 (successful transfers only; timeouts do not count), state=IDLE.
- Latency: request sample to per_send=1 is 1 cycle; per_ack to req_ack is 1 cycle. Minimum full transaction with a 1-cycle-responsive peripheral is 5 cycles IDLE-to-IDLE.
- The round-robin pointer advances only on completion, so a continuously requesting port cannot starve others.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Losers keep send high and are served later; their ack stays 0.
- A requester dropping send while in REQ is a protocol violation. The arbiter ignores it and completes the handshake; req_ack still rises.
- per_ack rising in IDLE or ACKD is ignored for grant purposes. ACKD exit depends only on req_send[W].
- After a timeout, a late per_ack is absorbed in REL, which waits for per_ack=0.
- xfer_cnt wraps from 2^CW-1 to 0.
- Reset mid-transaction aborts immediately: per_send=0, req_ack=0, grant=0. There is no partial-transfer recovery.

Decomposition:
- Shared package (cpu_per_pkg): state encoding constants IDLE=2'b00, REQ=2'b01, ACKD=2'b10, REL=2'b11, and the default data width constant shared with the CPU and peripheral FSMs.
- One sub-module, rr_pick: combinational round-robin selector (inputs req vector and rr_ptr; outputs one-hot winner and valid). Reused for any future multi-port arbiter.

Test Plan:
- Single request: req_send=01, req_dado[0]=2'b10, peripheral acks 1 cycle after per_send. Expect per_dado=2'b10, req_ack=01 one cycle after per_ack, xfer_cnt 0->1, grant back to 00 in REL+1.
- Simultaneous: req_send=11 held continuously, dado0=01, dado1=10. Expect grants alternating 01,10,01,10 and per_dado sequence 01,10,01,10 after reset.
- Timeout: TO_CYCLES=4, per_ack stuck 0, req_send=10. Expect per_send to fall after 4 REQ cycles, req_ack=10 with req_err=10, xfer_cnt unchanged.
- Stale ack: per_ack=1 held at release of reset with req_send=01. Expect no grant until per_ack=0, then normal transfer.
- Async reset during ACKD (rst2 pulsed low off-edge). Expect per_send, req_ack and grant =0 immediately; rr_ptr=0; a fresh request after reset completes normally.
- Counter wrap: CW=2, run 5 successful transfers. Expect xfer_cnt sequence 1,2,3,0,1.
